ps2_host_tx: RTL and testbench

// - Host-to-device PS/2 transmitter: the send-side counterpart to the PS/2 keyboard receiver.
// - Sends command bytes to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the shared clock/data lines.
// - Memory-mapped peripheral on the mmapper slave bus (a/d/we/spo); runs on clk_main.
// - Drives open-drain pad enables; the top level ties the tristate buffers to the same pins the receiver uses.

---
 rtl/ps2_host_tx.sv | 209 ++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx - host-to-device PS/2 transmitter on the mmapper slave bus.
//
// Sends one command byte to a PS/2 device: inhibits the bus, issues the
// request-to-send, shifts 8 data bits + odd parity + stop on the device's
// falling clock edges, then samples the device ACK.
//
// Ports
//   clk, rst_n          system clock, async active-low reset
//   a, d, we, spo       register bus (a=0 TX byte / last byte, a=1 status / clear)
//   kclk_i, kdata_i     PS/2 pin levels (asynchronous)
//   kclk_oe, kdata_oe   1 = pull the pin low (open drain)
//   irq                 transfer-complete level
//
// Status (a=1): {27'b0, DROP, TMO, NACK, DONE, BUSY}
//
// Build option: define PS2TX_IRQ_EN to enable irq (set with DONE or TMO,
// cleared by writing 1 to a=1 bit 0). Undefined: irq is tied to 0.
module ps2_host_tx #(
    parameter int CLOCK_FREQ     = 62500000,
    parameter int INHIBIT_CYCLES = 6250,
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  a,
    input  logic [31:0] d,
    input  logic        we,
    output logic [31:0] spo,
    input  logic        kclk_i,
    input  logic        kdata_i,
    output logic        kclk_oe,
    output logic        kdata_oe,
    output logic        irq
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;

    localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] INH_LD = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LD = CW'(TIMEOUT_CYCLES - 1);

    if (INHIBIT_CYCLES < 1 || TIMEOUT_CYCLES < 1 || CLOCK_FREQ < 1) begin : g_bad_param
        $error("ps2_host_tx: CLOCK_FREQ, INHIBIT_CYCLES and TIMEOUT_CYCLES must be positive");
    end

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;       // inhibit length, then inter-edge timeout
    logic [3:0]    r_bit;       // device falling edges seen in SHIFT
    logic [7:0]    r_byte;      // latched byte, also the "last byte" readback
    logic [7:0]    r_shift;
    logic [1:0]    r_kclk_sync, r_kdat_sync;
    logic          r_kclk_prev;
    logic          r_kclk_oe, r_kdata_oe;
    logic          r_done, r_nack, r_tmo, r_drop, r_irq;

    logic w_clk, w_dat, w_fall, w_busy, w_wr_tx, w_wr_clr;
    logic w_active, w_set_done, w_set_tmo, w_set_nack, w_set_drop;
    logic w_unused_d;

    assign w_clk    = r_kclk_sync[1];
    assign w_dat    = r_kdat_sync[1];
    assign w_fall   = r_kclk_prev & ~w_clk;
    assign w_busy   = (r_state != S_IDLE);
    assign w_wr_tx  = we && (a == 3'd0);
    assign w_wr_clr = we && (a == 3'd1) && d[0];
    assign w_unused_d = ^d[31:8];

    // States in which the device owns the clock and the timeout runs.
    assign w_active   = (r_state == S_REQ) || (r_state == S_SHIFT) ||
                        (r_state == S_ACK) || (r_state == S_WAIT);
    assign w_set_done = (r_state == S_WAIT) && w_clk && w_dat;
    assign w_set_tmo  = w_active && !w_fall && (r_cnt == '0) && !w_set_done;
    assign w_set_nack = (r_state == S_ACK) && w_fall && w_dat;
    assign w_set_drop = w_wr_tx && w_busy;

    // Synchronizers reset to the idle (released) bus level so reset
    // release never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_kclk_sync <= 2'b11;
            r_kdat_sync <= 2'b11;
            r_kclk_prev <= 1'b1;
        end else begin
            r_kclk_sync <= {r_kclk_sync[0], kclk_i};
            r_kdat_sync <= {r_kdat_sync[0], kdata_i};
            r_kclk_prev <= w_clk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit      <= 4'd0;
            r_byte     <= 8'h00;
            r_shift    <= 8'h00;
            r_kclk_oe  <= 1'b0;
            r_kdata_oe <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_tx) begin
                        r_byte     <= d[7:0];
                        r_shift    <= d[7:0];
                        r_cnt      <= INH_LD;
                        r_kclk_oe  <= 1'b1;
                        r_kdata_oe <= (INHIBIT_CYCLES == 1);
                        r_state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (r_cnt == '0) begin
                        r_kclk_oe <= 1'b0;
                        r_cnt     <= TMO_LD;
                        r_state   <= S_REQ;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        // start bit goes out during the last inhibit cycle
                        if (r_cnt == CW'(1)) r_kdata_oe <= 1'b1;
                    end
                end
                S_REQ, S_SHIFT, S_ACK, S_WAIT: begin
                    if (w_set_tmo) begin
                        r_kclk_oe  <= 1'b0;
                        r_kdata_oe <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= w_fall ? TMO_LD : r_cnt - 1'b1;
                        case (r_state)
                            S_REQ: begin
                                r_bit   <= 4'd0;
                                r_state <= S_SHIFT;
                            end
                            S_SHIFT: begin
                                if (w_fall) begin
                                    r_bit <= r_bit + 4'd1;
                                    if (r_bit < 4'd8) begin
                                        r_kdata_oe <= ~r_shift[0];
                                        r_shift    <= {1'b0, r_shift[7:1]};
                                    end else if (r_bit == 4'd8) begin
                                        // odd parity bit is ~^byte; pin enable is its inverse
                                        r_kdata_oe <= ^r_byte;
                                    end else begin
                                        r_kdata_oe <= 1'b0;
                                        r_state    <= S_ACK;
                                    end
                                end
                            end
                            S_ACK:   if (w_fall) r_state <= S_WAIT;
                            default: if (w_set_done) r_state <= S_IDLE;
                        endcase
                    end
                end
                default: begin
                    r_kclk_oe  <= 1'b0;
                    r_kdata_oe <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Flags: a clear and a set in the same cycle resolve to set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done <= 1'b0;
            r_nack <= 1'b0;
            r_tmo  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_done <= (r_done & ~w_wr_clr) | w_set_done;
            r_nack <= (r_nack & ~w_wr_clr) | w_set_nack;
            r_tmo  <= (r_tmo  & ~w_wr_clr) | w_set_tmo;
            r_drop <= (r_drop & ~w_wr_clr) | w_set_drop;
        end
    end

`ifdef PS2TX_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= (r_irq & ~w_wr_clr) | w_set_done | w_set_tmo;
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= 1'b0;
    end
`endif

    always_comb begin
        spo = 32'd0;
        case (a)
            3'd0:    spo = {24'd0, r_byte};
            3'd1:    spo = {27'd0, r_drop, r_tmo, r_nack, r_done, w_busy};
            default: spo = 32'd0;
        endcase
    end

    assign kclk_oe  = r_kclk_oe;
    assign kdata_oe = r_kdata_oe;
    assign irq      = r_irq;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model (scaled timing).
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 400;
    localparam int H   = 80;   // device clock half period (8 system clocks)

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  a = 3'd0;
    logic [31:0] d = 32'd0;
    logic        we = 1'b0;
    logic [31:0] spo;
    logic        kclk_oe, kdata_oe, irq;
    logic        dev_clow = 1'b0, dev_dlow = 1'b0;
    logic        kclk_pad, kdata_pad;

    assign kclk_pad  = ~(kclk_oe | dev_clow);
    assign kdata_pad = ~(kdata_oe | dev_dlow);

    always #5 clk = ~clk;

    ps2_host_tx #(.CLOCK_FREQ(62500000), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .d(d), .we(we), .spo(spo),
        .kclk_i(kclk_pad), .kdata_i(kdata_pad),
        .kclk_oe(kclk_oe), .kdata_oe(kdata_oe), .irq(irq)
    );

    int n_chk = 0, n_fail = 0;   // main-thread comparisons
    int c_chk = 0, c_fail = 0;   // per-cycle compare process
    int dev_edges = 0;
    int m_rel = 0;               // bumped by main thread when it sees BUSY drop

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic ccheck(input string name, input logic [31:0] act, input logic [31:0] exp);
        c_chk++;
        if (act !== exp) begin
            c_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    logic       s_we;
    logic [2:0] s_a;
    logic [31:0] s_d;
    always @(posedge clk) begin
        s_we <= we;
        s_a  <= a;
        s_d  <= d;
    end

    bit       m_busy = 0, m_drop = 0;
    int       inh_k = -1, seen_rel = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_drop = 0; inh_k = -1;
        end else begin
            if (m_rel != seen_rel) begin seen_rel = m_rel; m_busy = 0; end
            if (s_we && s_a == 3'd1 && s_d[0]) m_drop = 0;
            if (s_we && s_a == 3'd0) begin
                if (m_busy) m_drop = 1;
                else begin m_busy = 1; inh_k = 0; end
            end
        end
        if (inh_k >= 0) begin
            inh_k++;
            if (inh_k <= INH) begin
                ccheck("inhibit kclk_oe", 32'(kclk_oe), 32'd1);
                ccheck("inhibit kdata_oe", 32'(kdata_oe), 32'(inh_k == INH));
            end else begin
                ccheck("req kclk_oe", 32'(kclk_oe), 32'd0);
                ccheck("req kdata_oe", 32'(kdata_oe), 32'd1);
                inh_k = -1;
            end
        end else if (!m_busy) begin
            ccheck("idle oe", {30'd0, kclk_oe, kdata_oe}, 32'd0);
        end
`ifndef PS2TX_IRQ_EN
        ccheck("irq tied low", 32'(irq), 32'd0);
`endif
    end

    // ---------------- bus and device helpers ----------------
    task automatic wr(input logic [2:0] aa, input logic [31:0] dd);
        @(negedge clk); a = aa; d = dd; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] aa, output logic [31:0] v);
        @(negedge clk); a = aa; #1 v = spo;
    endtask

    task automatic wait_idle(input int bound);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < bound && v[0]; i++) rd(3'd1, v);
        check("busy drops within bound", v[0], 32'd0);
        m_rel++;
    endtask

    // Device: waits for request-to-send, clocks 11 bits, samples on rising edges.
    task automatic dev_xfer(input bit ack, output logic [10:0] rx, output bit ok);
        ok = 0; rx = '0; dev_edges = 0;
        for (int i = 0; i < INH + 100 && !ok; i++) begin
            @(negedge clk);
            if (kclk_pad && !kdata_pad) ok = 1;
        end
        if (ok) begin
            for (int i = 1; i <= 11; i++) begin
                if (i == 11 && ack) dev_dlow = 1'b1;
                #(H); dev_clow = 1'b1; dev_edges = i;
                #(H); dev_clow = 1'b0; rx[i-1] = kdata_pad;
            end
            #(H); dev_dlow = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] b, input logic [10:0] rx, input bit ok);
        check({tag, " request seen"}, 32'(ok), 32'd1);
        check({tag, " data byte"}, 32'(rx[7:0]), 32'(b));
        check({tag, " odd parity"}, 32'(rx[8]), 32'(~^b));
        check({tag, " stop bit"}, 32'(rx[9]), 32'd1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [10:0] rx;
        bit ok;

        repeat (3) @(negedge clk);
        rd(3'd1, v); check("reset status", v, 32'h0);
        rd(3'd0, v); check("reset last byte", v, 32'h0);
        check("reset oe", {kclk_oe, kdata_oe}, 32'h0);
        check("reset irq", 32'(irq), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: 0xED, ACK
        wr(3'd0, 32'hED);
        dev_xfer(1'b1, rx, ok);
        wait_idle(200);
        check_frame("0xED", 8'hED, rx, ok);
        check("0xED parity literal", 32'(rx[8]), 32'd1);
        check("0xED ack driven", 32'(rx[10]), 32'd0);
        rd(3'd1, v); check("0xED status", v, 32'h02);
        rd(3'd0, v); check("0xED last byte", v, 32'hED);
`ifdef PS2TX_IRQ_EN
        check("irq after done", 32'(irq), 32'd1);
`endif
        wr(3'd1, 32'h1);
        #1 check("irq after clear", 32'(irq), 32'd0);
        rd(3'd1, v); check("status after clear", v, 32'h00);

        // 2: 0xFF, NACK
        wr(3'd0, 32'hFF);
        dev_xfer(1'b0, rx, ok);
        wait_idle(200);
        check_frame("0xFF", 8'hFF, rx, ok);
        rd(3'd1, v); check("nack status", v, 32'h06);
        wr(3'd1, 32'h1);

        // 3: device never clocks -> timeout
        wr(3'd0, 32'h12);
        wait_idle(INH + TMO + 50);
        rd(3'd1, v); check("timeout status", v, 32'h08);
        check("timeout oe released", {kclk_oe, kdata_oe}, 32'h0);
`ifdef PS2TX_IRQ_EN
        check("irq after timeout", 32'(irq), 32'd1);
`endif
        wr(3'd1, 32'h1);

        // 4: 0x55, then 0xAA mid-transfer is dropped
        wr(3'd0, 32'h55);
        fork
            dev_xfer(1'b1, rx, ok);
            begin
                for (int i = 0; i < 2000 && dev_edges < 3; i++) @(negedge clk);
                wr(3'd0, 32'hAA);
            end
        join
        wait_idle(200);
        check_frame("0x55", 8'h55, rx, ok);
        rd(3'd1, v); check("drop status (model)", v, {27'd0, m_drop, 4'b0010});
        check("drop status literal", v, 32'h12);
        rd(3'd0, v); check("dropped byte not latched", v, 32'h55);
        repeat (INH + 20) @(negedge clk);   // compare process watches for a stray transfer
        wr(3'd1, 32'h1);

        // 5: reset during SHIFT bit 4, then 0xF4 completes
        wr(3'd0, 32'h3C);
        fork
            dev_xfer(1'b1, rx, ok);
            begin
                for (int i = 0; i < 2000 && dev_edges < 4; i++) @(negedge clk);
                check("reached shift bit 4", 32'(dev_edges), 32'd4);
                #22 rst_n = 1'b0;
                #1 check("oe cleared by async reset", {kclk_oe, kdata_oe}, 32'h0);
                rd(3'd1, v); check("status in reset", v, 32'h0);
                rd(3'd0, v); check("last byte in reset", v, 32'h0);
                check("irq in reset", 32'(irq), 32'h0);
                @(negedge clk); rst_n = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        wr(3'd0, 32'hF4);
        dev_xfer(1'b1, rx, ok);
        wait_idle(200);
        check_frame("0xF4", 8'hF4, rx, ok);
        check("0xF4 parity literal", 32'(rx[8]), 32'd0);
        rd(3'd1, v); check("0xF4 status", v, 32'h02);
        rd(3'd0, v); check("0xF4 last byte", v, 32'hF4);

        repeat (5) @(negedge clk);
        n_chk  = n_chk + c_chk;
        n_fail = n_fail + c_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
